// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with skid buffer; define IMMGEN_RVC_EN for compressed decode
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6;
  logic [XLEN-1:0]  d_imm, s_imm;
  logic [2:0]       d_fmt, s_fmt;
  logic             d_ill, s_ill, skid_valid, in_xfer;
  logic [TAG_W-1:0] s_tag;
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
`ifdef IMMGEN_RVC_EN
  localparam logic [2:0] F_C = 3'd7;
  logic [15:0]     c;
  logic [XLEN-1:0] c_j;
  assign c   = in_insn[15:0];
  assign c_j = XLEN'($signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0}));
`endif
  // combinational decode of the incoming instruction
  always_comb begin
    d_imm = '0;
    d_fmt = F_NONE;
    d_ill = 1'b0;
    if (in_insn[1:0] == 2'b11) begin
      case (in_insn[6:0])
        7'h03, 7'h13, 7'h67: begin
          d_fmt = F_I;
          d_imm = XLEN'($signed(in_insn[31:20]));
        end
        7'h1B: begin
          d_ill = (XLEN != 64);
          d_fmt = (XLEN == 64) ? F_I : F_NONE;
          d_imm = (XLEN == 64) ? XLEN'($signed(in_insn[31:20])) : '0;
        end
        7'h23: begin
          d_fmt = F_S;
          d_imm = XLEN'($signed({in_insn[31:25], in_insn[11:7]}));
        end
        7'h63: begin
          d_fmt = F_B;
          d_imm = XLEN'($signed({in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0}));
        end
        7'h37, 7'h17: begin
          d_fmt = F_U;
          d_imm = XLEN'($signed({in_insn[31:12], 12'b0}));
        end
        7'h6F: begin
          d_fmt = F_J;
          d_imm = XLEN'($signed({in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0}));
        end
        7'h73: begin
          d_fmt = (in_insn[14:12] >= 3'd4) ? F_Z : F_NONE;
          d_imm = (in_insn[14:12] >= 3'd4) ? XLEN'(in_insn[19:15]) : '0;
        end
        7'h33, 7'h0F: d_ill = 1'b0;
        7'h3B: d_ill = (XLEN != 64);
        default: d_ill = 1'b1;
      endcase
    end else begin
`ifdef IMMGEN_RVC_EN
      d_ill = 1'b1;
      if (c[1:0] == 2'b01) begin
        case (c[15:13])
          3'b000, 3'b010: begin
            d_ill = 1'b0;
            d_fmt = F_C;
            d_imm = XLEN'($signed({c[12], c[6:2]}));
          end
          3'b101: begin
            d_ill = 1'b0;
            d_fmt = F_C;
            d_imm = c_j;
          end
          3'b001: begin
            d_ill = (XLEN != 32);
            d_fmt = (XLEN == 32) ? F_C : F_NONE;
            d_imm = (XLEN == 32) ? c_j : '0;
          end
          3'b110, 3'b111: begin
            d_ill = 1'b0;
            d_fmt = F_C;
            d_imm = XLEN'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
          end
          default: d_ill = 1'b1;
        endcase
      end
`else
      d_ill = 1'b1;
`endif
    end
  end
  // output register fed by skid first, then input; skid catches input while output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= F_NONE;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      s_imm       <= '0;
      s_fmt       <= F_NONE;
      s_ill       <= 1'b0;
      s_tag       <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || in_xfer;
      if (skid_valid) begin
        out_imm     <= s_imm;
        out_fmt     <= s_fmt;
        out_illegal <= s_ill;
        out_tag     <= s_tag;
        skid_valid  <= 1'b0;
      end else if (in_xfer) begin
        out_imm     <= d_imm;
        out_fmt     <= d_fmt;
        out_illegal <= d_ill;
        out_tag     <= in_tag;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      s_imm      <= d_imm;
      s_fmt      <= d_fmt;
      s_ill      <= d_ill;
      s_tag      <= in_tag;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors, handshake sequences and random scoreboard for XLEN=32 and XLEN=64 instances
module tb_imm_gen_pipe;
  localparam logic [2:0] NONE = 3'd0, FI = 3'd1, FS = 3'd2, FB = 3'd3, FU = 3'd4, FJ = 3'd5, FZ = 3'd6, FC = 3'd7;
  localparam logic [6:0] OPS [14] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                                      7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h3B, 7'h7F};
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_insn = '0;
  logic [7:0] in_tag = '0;
  logic r32, v32, il32, r64, v64, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0] f32, f64;
  logic [7:0] t32, t64;
  int checks = 0, errors = 0;

  typedef struct { logic [63:0] imm; logic [2:0] fmt; logic ill; logic [7:0] tag; } res_t;
  typedef struct { logic [31:0] insn; logic [31:0] imm32; logic [2:0] f32; logic il32;
                   logic [63:0] imm64; logic [2:0] f64; logic il64; } vec_t;
  res_t q32[$], q64[$];
  vec_t tv[13];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .in_insn(in_insn), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(f32), .out_illegal(il32), .out_tag(t32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64), .in_insn(in_insn), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(f64), .out_illegal(il64), .out_tag(t64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string n, input logic ev, input vec_t e, input logic [7:0] etag);
    chk({n, "_v32"}, v32, ev);
    chk({n, "_imm32"}, imm32, e.imm32);
    chk({n, "_fmt32"}, f32, e.f32);
    chk({n, "_ill32"}, il32, e.il32);
    chk({n, "_tag32"}, t32, etag);
    chk({n, "_v64"}, v64, ev);
    chk({n, "_imm64"}, imm64, e.imm64);
    chk({n, "_fmt64"}, f64, e.f64);
    chk({n, "_ill64"}, il64, e.il64);
    chk({n, "_tag64"}, t64, etag);
  endtask

  function automatic longint sx(longint v, int n);
    return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
  endfunction

  function automatic longint fld(logic [31:0] w, int lo, int n);
    return longint'((w >> lo) & ((32'd1 << n) - 32'd1));
  endfunction

  // reference decode: immediate value assembled arithmetically from the field positions
  function automatic res_t model(logic [31:0] w, bit x64);
    res_t r;
    longint v;
    longint op, f3;
    r.fmt = NONE; r.ill = 1'b0; r.tag = '0; v = 0;
    op = fld(w, 0, 7);
    if (fld(w, 0, 2) == 3) begin
      case (op)
        'h03, 'h13, 'h67: begin r.fmt = FI; v = sx(fld(w, 20, 12), 12); end
        'h1B: if (x64) begin r.fmt = FI; v = sx(fld(w, 20, 12), 12); end else r.ill = 1'b1;
        'h23: begin r.fmt = FS; v = sx(fld(w, 25, 7) * 32 + fld(w, 7, 5), 12); end
        'h63: begin r.fmt = FB; v = sx(fld(w, 31, 1) * 4096 + fld(w, 7, 1) * 2048 + fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2, 13); end
        'h37, 'h17: begin r.fmt = FU; v = sx(fld(w, 12, 20) * 4096, 32); end
        'h6F: begin r.fmt = FJ; v = sx(fld(w, 31, 1) * 1048576 + fld(w, 12, 8) * 4096 + fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2, 21); end
        'h73: if (fld(w, 14, 1) == 1) begin r.fmt = FZ; v = fld(w, 15, 5); end
        'h33, 'h0F: r.ill = 1'b0;
        'h3B: r.ill = !x64;
        default: r.ill = 1'b1;
      endcase
    end else begin
      r.ill = 1'b1;
`ifdef IMMGEN_RVC_EN
      f3 = fld(w, 13, 3);
      if (fld(w, 0, 2) == 1) begin
        if (f3 == 0 || f3 == 2) begin
          r.ill = 1'b0; r.fmt = FC; v = sx(fld(w, 12, 1) * 32 + fld(w, 2, 5), 6);
        end else if (f3 == 5 || (f3 == 1 && !x64)) begin
          r.ill = 1'b0; r.fmt = FC;
          v = sx(fld(w, 12, 1) * 2048 + fld(w, 11, 1) * 16 + fld(w, 9, 2) * 256 + fld(w, 8, 1) * 1024 +
                 fld(w, 7, 1) * 64 + fld(w, 6, 1) * 128 + fld(w, 3, 3) * 2 + fld(w, 2, 1) * 32, 12);
        end else if (f3 >= 6) begin
          r.ill = 1'b0; r.fmt = FC;
          v = sx(fld(w, 12, 1) * 256 + fld(w, 5, 2) * 64 + fld(w, 2, 1) * 32 + fld(w, 10, 2) * 8 + fld(w, 3, 2) * 2, 9);
        end
      end
`else
      f3 = 0;
`endif
    end
    r.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      w[31:16] = '0;
      w[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 2));
    end else w[6:0] = OPS[$urandom_range(0, 13)];
    return w;
  endfunction

  // sampled mid-cycle: score output transfers against the queues, then record input transfers
  task automatic score();
    res_t e;
    if (v32 && out_ready) begin
      checks++;
      if (q32.size() == 0) begin errors++; $display("FAIL rnd32_spurious: got tag %0h expected none", t32); end
      else begin
        checks--;
        e = q32.pop_front();
        chk("rnd32_imm", imm32, e.imm); chk("rnd32_fmt", f32, e.fmt);
        chk("rnd32_ill", il32, e.ill); chk("rnd32_tag", t32, e.tag);
      end
    end
    if (v64 && out_ready) begin
      checks++;
      if (q64.size() == 0) begin errors++; $display("FAIL rnd64_spurious: got tag %0h expected none", t64); end
      else begin
        checks--;
        e = q64.pop_front();
        chk("rnd64_imm", imm64, e.imm); chk("rnd64_fmt", f64, e.fmt);
        chk("rnd64_ill", il64, e.ill); chk("rnd64_tag", t64, e.tag);
      end
    end
    if (in_valid && r32) begin e = model(in_insn, 1'b0); e.tag = in_tag; q32.push_back(e); end
    if (in_valid && r64) begin e = model(in_insn, 1'b1); e.tag = in_tag; q64.push_back(e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t z;
    tv[0]  = '{32'hFFF00093, 32'hFFFFFFFF, FI, 1'b0, 64'hFFFFFFFFFFFFFFFF, FI, 1'b0};
    tv[1]  = '{32'h0040006F, 32'h00000004, FJ, 1'b0, 64'h4, FJ, 1'b0};
    tv[2]  = '{32'h123450B7, 32'h12345000, FU, 1'b0, 64'h12345000, FU, 1'b0};
    tv[3]  = '{32'h800000B7, 32'h80000000, FU, 1'b0, 64'hFFFFFFFF80000000, FU, 1'b0};
    tv[4]  = '{32'h0000101B, 32'h0, NONE, 1'b1, 64'h0, FI, 1'b0};
    tv[5]  = '{32'h300FD073, 32'h1F, FZ, 1'b0, 64'h1F, FZ, 1'b0};
    tv[6]  = '{32'hFE112E23, 32'hFFFFFFFC, FS, 1'b0, 64'hFFFFFFFFFFFFFFFC, FS, 1'b0};
    tv[7]  = '{32'hFE000EE3, 32'hFFFFFFFC, FB, 1'b0, 64'hFFFFFFFFFFFFFFFC, FB, 1'b0};
    tv[8]  = '{32'h00208033, 32'h0, NONE, 1'b0, 64'h0, NONE, 1'b0};
    tv[9]  = '{32'h0000007F, 32'h0, NONE, 1'b1, 64'h0, NONE, 1'b1};
    tv[10] = '{32'h0000003B, 32'h0, NONE, 1'b1, 64'h0, NONE, 1'b0};
    tv[11] = '{32'h00000073, 32'h0, NONE, 1'b0, 64'h0, NONE, 1'b0};
`ifdef IMMGEN_RVC_EN
    tv[12] = '{32'h000050FD, 32'hFFFFFFFF, FC, 1'b0, 64'hFFFFFFFFFFFFFFFF, FC, 1'b0};
`else
    tv[12] = '{32'h000050FD, 32'h0, NONE, 1'b1, 64'h0, NONE, 1'b1};
`endif
    z = '{32'h0, 32'h0, NONE, 1'b0, 64'h0, NONE, 1'b0};
    #1 rst_n = 1'b0;
    #10;
    cmp("reset", 1'b0, z, 8'h0);
    chk("reset_rdy32", r32, 1'b1);
    chk("reset_rdy64", r64, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      if (i < 13) begin
        in_valid = 1'b1; in_insn = tv[i].insn; in_tag = 8'(i + 16);
      end else in_valid = 1'b0;
      if (i > 0) cmp($sformatf("vec%0d", i - 1), 1'b1, tv[i - 1], 8'(i + 15));
      @(negedge clk);
    end
    chk("drained_v32", v32, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'hFFF00093; in_tag = 8'd1;
    @(negedge clk);
    chk("bp_rdy_a", r32, 1'b1); chk("bp_tag_a", t32, 8'd1); chk("bp_v_a", v32, 1'b1);
    in_tag = 8'd2; in_insn = 32'h0040006F;
    @(negedge clk);
    chk("bp_rdy_b32", r32, 1'b0); chk("bp_rdy_b64", r64, 1'b0); chk("bp_tag_b", t32, 8'd1);
    in_tag = 8'd3; in_insn = 32'h123450B7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_tag", t32, 8'd1); chk("bp_hold_imm", imm32, 32'hFFFFFFFF);
      chk("bp_hold_fmt", f32, FI); chk("bp_hold_v", v32, 1'b1); chk("bp_hold_rdy", r32, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out2_tag", t32, 8'd2); chk("bp_out2_imm", imm32, 32'h4); chk("bp_out2_fmt", f32, FJ);
    chk("bp_out2_rdy", r32, 1'b1);
    @(negedge clk);
    chk("bp_out3_tag32", t32, 8'd3); chk("bp_out3_tag64", t64, 8'd3); chk("bp_out3_imm", imm32, 32'h12345000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", v32, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'h41; in_insn = 32'hFFF00093;
    @(negedge clk);
    in_tag = 8'h42;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_full_rdy", r32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_v32", v32, 1'b0); chk("rst_async_rdy32", r32, 1'b1);
    chk("rst_async_v64", v64, 1'b0); chk("rst_async_rdy64", r64, 1'b1); chk("rst_async_tag", t32, 8'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_tag = 8'h55; in_insn = 32'h300FD073; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_v", v32, 1'b1); chk("post_rst_tag", t32, 8'h55);
    chk("post_rst_imm", imm32, 32'h1F); chk("post_rst_fmt", f32, FZ);
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_insn = rand_insn();
      in_tag = 8'($urandom);
      #1 score();
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1 score();
      @(negedge clk);
    end
    chk("rnd32_left", q32.size(), 0);
    chk("rnd64_left", q64.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage.
- Extracts and sign-extends the immediate of a 32-bit RISC-V instruction to XLEN bits, classifies its format, and flags unsupported encodings.
- Adds RV64 opcodes, CSR zimm, a valid/ready handshake with a registered output and a skid buffer, and optional compressed-instruction decode.
- Sits between fetch/instruction buffer and the decode/register-read stage.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64. Controls immediate extension and enables OP_IMM_32/OP_32.
- TAG_W, 8: width of the opaque sideband tag (e.g. ROB id / PC index) carried alongside each instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept; registered
- in_insn  in  32  instruction word; compressed instructions sit in [15:0]
- in_tag  in  TAG_W  sideband, passed through unmodified
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 C (compressed)
- out_illegal  out  1  encoding not supported
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Storage: output register plus one skid entry.
  - Accepted result goes to the output register if it is empty or transferring this cycle; otherwise it goes to the skid entry.
  - Skid entry moves to the output register on the next output transfer.
  - in_ready = !skid_valid.
  - Full throughput with out_ready=1; no bubbles, no loss, no duplication, order preserved.
- Output stability: while out_valid=1 and out_ready=0, out_* hold stable.
- Simultaneous input and output transfer with the skid entry full cannot occur, since in_ready=0 in that case.
- Decode (combinational, before the register), insn[1:0]=11:
  - LOAD 0x03, OP_IMM 0x13, JALR 0x67: I, sext(insn[31:20]).
  - OP_IMM_32 0x1B (XLEN=64 only): I.
  - STORE 0x23: S, sext({insn[31:25],insn[11:7]}).
  - BRANCH 0x63: B, sext({insn[31],insn[7],insn[30:25],insn[11:8],0}).
  - LUI 0x37, AUIPC 0x17: U, sext({insn[31:12],12'b0}); sign bit 31 extends to XLEN.
  - JAL 0x6F: J, sext({insn[31],insn[19:12],insn[20],insn[30:21],0}).
  - SYSTEM 0x73 with funct3[2]=1: Z, zero-extended insn[19:15].
  - SYSTEM with funct3[2]=0, OP 0x33, MISC_MEM 0x0F, OP_32 0x3B (XLEN=64 only): NONE, imm=0.
  - Anything else, including 0x1B/0x3B when XLEN=32: illegal=1, fmt=NONE, imm=0.
- insn[1:0]!=11: handled per the optional feature below.

Optional Feature:
- Macro: IMMGEN_RVC_EN.
- Defined: compressed instructions (insn[1:0]!=11) are decoded from insn[15:0] with fmt=C, illegal=0:
  - Quadrant 01, funct3 000 (C.ADDI) or 010 (C.LI): sext({i[12],i[6:2]}).
  - Quadrant 01, funct3 101 (C.J), or 001 (C.JAL) when XLEN=32: sext({i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0}).
  - Quadrant 01, funct3 110/111 (C.BEQZ/C.BNEZ): sext({i[12],i[6:5],i[2],i[11:10],i[4:3],0}).
  - All other compressed encodings: illegal=1, imm=0, fmt=NONE.
- Undefined: every insn[1:0]!=11 gives illegal=1, imm=0, fmt=NONE; fmt code 7 is never produced.

Test Plan:
- XLEN=32, out_ready=1, stream 0xFFF00093, 0x0040006F, 0x123450B7 on consecutive cycles:
  - Outputs on the following consecutive cycles: (0xFFFFFFFF, I), (0x00000004, J), (0x12345000, U).
  - Tags match the inputs; no bubbles.
- Backpressure: out_ready=0, push tags 1, 2, 3 with in_valid held:
  - Tag 1 appears in the output register, tag 2 goes to the skid entry, in_ready=0 from the cycle after the second accept.
  - Tag 3 is held upstream.
  - After out_ready=1, outputs appear in order 1, 2, 3 with out_* stable while stalled.
- XLEN=64, 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt U.
- XLEN=64, 0x0000101B -> fmt I, imm 0.
- XLEN=32, 0x0000101B -> illegal=1.
- 0x50FD (C.LI x1,-1):
  - With IMMGEN_RVC_EN: imm 0xFFFFFFFF, fmt C.
  - Without: illegal=1, imm 0.
- 0x300FD073 (CSRRWI, zimm=31): imm 0x1F, fmt Z.
- Reset mid-operation: assert rst_n=0 with both entries full -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; the first post-reset input emerges after 1 cycle.
